// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the I/Q transmitter frame scheduler.
package tx_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_TAIL
  } state_t;

  // Preamble alternates between these two values on the I rail; Q carries the complement.
  localparam logic [1:0] PREAMBLE_A = 2'b00;
  localparam logic [1:0] PREAMBLE_B = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tx_clk_ena_gen.sv
// Free-running sample/symbol enable generator. The sample enable fires once every
// CLK_PER_SAM clocks; the symbol enable fires on every SAM_PER_SYM-th sample enable.
module tx_clk_ena_gen #(
  parameter int CLK_PER_SAM = 4,
  parameter int SAM_PER_SYM = 4
) (
  input  logic clk,
  input  logic reset,
  output logic sam_clk_ena,
  output logic sym_clk_ena
);

  localparam int C_W = $clog2(CLK_PER_SAM);
  localparam int S_W = $clog2(SAM_PER_SYM);

  logic [C_W-1:0] c_reg;
  logic [S_W-1:0] s_reg;

  // Enables are decoded from the counters so the first sample lands on cycle CLK_PER_SAM-1.
  assign sam_clk_ena = (c_reg == C_W'(CLK_PER_SAM - 1));
  assign sym_clk_ena = sam_clk_ena && (s_reg == S_W'(SAM_PER_SYM - 1));

  // Clock and sample counters; both restart from zero on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_reg <= '0;
      s_reg <= '0;
    end else begin
      if (sam_clk_ena) c_reg <= '0;
      else             c_reg <= c_reg + 1'b1;
      if (sym_clk_ena)      s_reg <= '0;
      else if (sam_clk_ena) s_reg <= s_reg + 1'b1;
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Frame sequencer for the I/Q QAM transmitter: preamble, payload pulled by
// valid/ready, then idle tail symbols that flush the pulse-shaping filters.
module tx_frame_scheduler
  import tx_sched_pkg::*;
#(
  parameter int         CLK_PER_SAM  = 4,
  parameter int         SAM_PER_SYM  = 4,
  parameter int         PREAMBLE_LEN = 16,
  parameter int         TAIL_LEN     = 8,
  parameter int         LEN_W        = 10,
  parameter logic [1:0] IDLE_SYM     = 2'b00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             start_ack,
  input  logic             pay_valid,
  input  logic [1:0]       pay_i,
  input  logic [1:0]       pay_q,
  output logic             pay_ready,
  output logic             sam_clk_ena,
  output logic             sym_clk_ena,
  output logic [1:0]       syms_i,
  output logic [1:0]       syms_q,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int K_MAX = max3(PREAMBLE_LEN, TAIL_LEN, (1 << LEN_W) - 1);
  localparam int K_W   = $clog2(K_MAX + 1);

  state_t           state_reg;
  logic [K_W-1:0]   k_reg;       // symbols already issued in the current phase
  logic [LEN_W-1:0] len_reg;
  logic [1:0]       syms_i_reg;
  logic [1:0]       syms_q_reg;
  logic             start_ack_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             underrun_reg;

  logic             pre_done;
  logic             pay_slot;
  logic             tail_enter;
  logic             tail_cont;
  logic             tail_last;
  logic [K_W-1:0]   tail_count;
  logic [K_W-1:0]   len_k;

  tx_clk_ena_gen #(
    .CLK_PER_SAM(CLK_PER_SAM),
    .SAM_PER_SYM(SAM_PER_SYM)
  ) u_ena (
    .clk        (clk),
    .reset      (reset),
    .sam_clk_ena(sam_clk_ena),
    .sym_clk_ena(sym_clk_ena)
  );

  assign len_k = K_W'(len_reg);

  // Slot decode: payload request slots and entry/continuation/end of the idle tail.
  always_comb begin
    pre_done   = (k_reg == K_W'(PREAMBLE_LEN));
    pay_slot   = 1'b0;
    tail_enter = 1'b0;
    tail_cont  = 1'b0;
    if (sym_clk_ena) begin
      case (state_reg)
        ST_PREAMBLE: begin
          if (pre_done && len_reg != '0) pay_slot   = 1'b1;
          if (pre_done && len_reg == '0) tail_enter = 1'b1;
        end
        ST_PAYLOAD: begin
          if (k_reg < len_k) pay_slot   = 1'b1;
          else               tail_enter = 1'b1;
        end
        ST_TAIL: tail_cont = 1'b1;
        default: ;
      endcase
      // A missing payload symbol aborts the frame straight into the tail.
      if (pay_slot && !pay_valid) tail_enter = 1'b1;
    end
    tail_count = tail_enter ? '0 : k_reg;
    tail_last  = (tail_enter || tail_cont) && (tail_count == K_W'(TAIL_LEN - 1));
  end

  assign pay_ready = pay_slot;
  assign start_ack = start_ack_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign underrun  = underrun_reg;
  assign syms_i    = syms_i_reg;
  assign syms_q    = syms_q_reg;

  // Frame FSM with symbol counter and registered symbol/flag outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      k_reg         <= '0;
      len_reg       <= '0;
      syms_i_reg    <= IDLE_SYM;
      syms_q_reg    <= IDLE_SYM;
      start_ack_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      start_ack_reg <= 1'b0;
      done_reg      <= 1'b0;
      // busy stays up through the done cycle and falls right after it.
      if (done_reg) busy_reg <= 1'b0;
      if (pay_slot && !pay_valid) underrun_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          // busy_reg still high on the done cycle, so a start there is ignored.
          if (start && !busy_reg) begin
            start_ack_reg <= 1'b1;
            busy_reg      <= 1'b1;
            len_reg       <= frame_len;
            underrun_reg  <= 1'b0;
            k_reg         <= '0;
            state_reg     <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (sym_clk_ena) begin
            syms_i_reg <= PREAMBLE_A;
            syms_q_reg <= ~PREAMBLE_A;
            k_reg      <= K_W'(1);
            state_reg  <= ST_PREAMBLE;
          end
        end
        ST_PREAMBLE, ST_PAYLOAD, ST_TAIL: begin
          if (sym_clk_ena) begin
            if (tail_last) begin
              syms_i_reg <= IDLE_SYM;
              syms_q_reg <= IDLE_SYM;
              done_reg   <= 1'b1;
              k_reg      <= '0;
              state_reg  <= ST_IDLE;
            end else if (tail_enter || tail_cont) begin
              syms_i_reg <= IDLE_SYM;
              syms_q_reg <= IDLE_SYM;
              k_reg      <= tail_count + 1'b1;
              state_reg  <= ST_TAIL;
            end else if (pay_slot) begin
              syms_i_reg <= pay_i;
              syms_q_reg <= pay_q;
              k_reg      <= (state_reg == ST_PAYLOAD) ? k_reg + 1'b1 : K_W'(1);
              state_reg  <= ST_PAYLOAD;
            end else begin
              syms_i_reg <= k_reg[0] ? PREAMBLE_B : PREAMBLE_A;
              syms_q_reg <= k_reg[0] ? ~PREAMBLE_B : ~PREAMBLE_A;
              k_reg      <= k_reg + 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with default parameters.
module tb_tx_frame_scheduler;

  localparam int PRE  = 16;
  localparam int TAIL = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] frame_len = '0;
  logic       pay_valid = 1'b0;
  logic [1:0] pay_i = 2'b00;
  logic [1:0] pay_q = 2'b00;
  logic       start_ack, pay_ready, sam_clk_ena, sym_clk_ena;
  logic [1:0] syms_i, syms_q;
  logic       busy, done, underrun;

  int n_vec = 0;
  int n_bad = 0;

  logic [1:0] tab_i [8];
  logic [1:0] tab_q [8];
  logic [3:0] seen [$];

  always #5 clk = ~clk;

  tx_frame_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frame_len  (frame_len),
    .start_ack  (start_ack),
    .pay_valid  (pay_valid),
    .pay_i      (pay_i),
    .pay_q      (pay_q),
    .pay_ready  (pay_ready),
    .sam_clk_ena(sam_clk_ena),
    .sym_clk_ena(sym_clk_ena),
    .syms_i     (syms_i),
    .syms_q     (syms_q),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame and compares the issued symbol stream; returns on the cycle after done.
  task automatic run_frame(input int tn, input int len, input int drop, input bit hold);
    int pay_idx, n_ready, n_acks, cyc, n_pay, exp_ready, exp_len;
    bit prev_sym, got_done, aborted;
    logic [3:0] e;
    start = 1'b1;
    frame_len = 10'(len);
    step();
    if (!hold) start = 1'b0;
    check_eq($sformatf("t%0d_ack", tn), 32'(start_ack), 32'd1);
    check_eq($sformatf("t%0d_busy_at_ack", tn), 32'(busy), 32'd1);
    check_eq($sformatf("t%0d_underrun_clr", tn), 32'(underrun), 32'd0);
    seen.delete();
    pay_idx = 0; n_ready = 0; n_acks = 0; cyc = 0;
    prev_sym = 1'b0; got_done = 1'b0;
    while (!got_done && cyc < 3000) begin
      if (prev_sym) seen.push_back({syms_i, syms_q});
      if (start_ack) n_acks++;
      if (done) begin
        got_done = 1'b1;
      end else begin
        pay_valid = (pay_idx != drop);
        pay_i = tab_i[pay_idx % 8];
        pay_q = tab_q[pay_idx % 8];
        prev_sym = sym_clk_ena;
        if (pay_ready) begin
          n_ready++;
          pay_idx++;
        end
        step();
        cyc++;
      end
    end
    pay_valid = 1'b0;
    check_eq($sformatf("t%0d_done_seen", tn), 32'(got_done), 32'd1);
    check_eq($sformatf("t%0d_busy_on_done", tn), 32'(busy), 32'd1);
    check_eq($sformatf("t%0d_acks", tn), 32'(n_acks), 32'd1);
    aborted   = (drop >= 0 && drop < len);
    n_pay     = aborted ? drop : len;
    exp_ready = aborted ? drop + 1 : len;
    exp_len   = PRE + n_pay + TAIL;
    check_eq($sformatf("t%0d_ready_pulses", tn), 32'(n_ready), 32'(exp_ready));
    check_eq($sformatf("t%0d_underrun", tn), 32'(underrun), 32'(aborted));
    check_eq($sformatf("t%0d_nsyms", tn), 32'(seen.size()), 32'(exp_len));
    for (int i = 0; i < exp_len && i < seen.size(); i++) begin
      if (i < PRE)              e = (i % 2 == 1) ? 4'b1100 : 4'b0011;
      else if (i < PRE + n_pay) e = {tab_i[i - PRE], tab_q[i - PRE]};
      else                      e = 4'b0000;
      check_eq($sformatf("t%0d_sym%0d", tn, i), 32'(seen[i]), 32'(e));
    end
    step();
    check_eq($sformatf("t%0d_done_once", tn), 32'(done), 32'd0);
    check_eq($sformatf("t%0d_busy_drop", tn), 32'(busy), 32'd0);
    $display("frame t%0d len=%0d: %0d symbols, %0d ready pulses, underrun=%0d",
             tn, len, seen.size(), n_ready, underrun);
  endtask

  initial begin
    int first_sam, first_sym, cyc;
    bit seen_ready;

    // Test 1: reset state, then enable cadence after release.
    repeat (3) step();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ack", 32'(start_ack), 32'd0);
    check_eq("rst_underrun", 32'(underrun), 32'd0);
    check_eq("rst_syms", 32'({syms_i, syms_q}), 32'd0);
    check_eq("rst_sam", 32'(sam_clk_ena), 32'd0);
    check_eq("rst_sym", 32'(sym_clk_ena), 32'd0);
    check_eq("rst_ready", 32'(pay_ready), 32'd0);
    reset = 1'b0;
    for (int n = 0; n < 64; n++) begin
      check_eq($sformatf("t1_sam_c%0d", n), 32'(sam_clk_ena), 32'(n % 4 == 3));
      check_eq($sformatf("t1_sym_c%0d", n), 32'(sym_clk_ena), 32'(n % 16 == 15));
      step();
    end
    check_eq("t1_syms_idle", 32'({syms_i, syms_q}), 32'd0);
    $display("t1 enable cadence checked over 64 cycles");

    // Test 2: three payload symbols, no underrun.
    tab_i[0] = 2'b01; tab_q[0] = 2'b10;
    tab_i[1] = 2'b11; tab_q[1] = 2'b00;
    tab_i[2] = 2'b10; tab_q[2] = 2'b01;
    for (int i = 3; i < 8; i++) begin tab_i[i] = 2'b00; tab_q[i] = 2'b00; end
    run_frame(2, 3, -1, 1'b0);

    // Test 3: five requested, valid dropped at the third slot.
    tab_i[0] = 2'b10; tab_q[0] = 2'b11;
    tab_i[1] = 2'b01; tab_q[1] = 2'b01;
    tab_i[2] = 2'b11; tab_q[2] = 2'b11;
    tab_i[3] = 2'b11; tab_q[3] = 2'b10;
    tab_i[4] = 2'b01; tab_q[4] = 2'b00;
    run_frame(3, 5, 2, 1'b0);

    // Test 4: empty payload; also confirms underrun cleared by the ack.
    run_frame(4, 0, -1, 1'b0);

    // Test 5: start held high for the whole frame.
    tab_i[0] = 2'b00; tab_q[0] = 2'b01;
    tab_i[1] = 2'b11; tab_q[1] = 2'b10;
    run_frame(5, 2, -1, 1'b1);
    check_eq("t5_no_ack_busy_low", 32'(start_ack), 32'd0);
    step();
    check_eq("t5_reack", 32'(start_ack), 32'd1);
    check_eq("t5_reack_busy", 32'(busy), 32'd1);
    start = 1'b0;
    $display("t5 re-accepted start after busy dropped");

    // Test 6: reset in the middle of the payload of the frame just started.
    pay_valid = 1'b1;
    seen_ready = 1'b0;
    cyc = 0;
    while (!seen_ready && cyc < 2000) begin
      if (pay_ready) seen_ready = 1'b1;
      step();
      cyc++;
    end
    check_eq("t6_reached_payload", 32'(seen_ready), 32'd1);
    step();
    reset = 1'b1;
    step();
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_syms", 32'({syms_i, syms_q}), 32'd0);
    check_eq("t6_sam", 32'(sam_clk_ena), 32'd0);
    check_eq("t6_sym", 32'(sym_clk_ena), 32'd0);
    check_eq("t6_ready", 32'(pay_ready), 32'd0);
    check_eq("t6_ack", 32'(start_ack), 32'd0);
    pay_valid = 1'b0;
    step();
    reset = 1'b0;
    first_sam = -1;
    first_sym = -1;
    for (int n = 0; n < 20; n++) begin
      if (sam_clk_ena && first_sam < 0) first_sam = n;
      if (sym_clk_ena && first_sym < 0) first_sym = n;
      step();
    end
    check_eq("t6_first_sam", 32'(first_sam), 32'd3);
    check_eq("t6_first_sym", 32'(first_sym), 32'd15);
    check_eq("t6_idle_busy", 32'(busy), 32'd0);
    $display("t6 reset mid-payload: first sam %0d, first sym %0d", first_sam, first_sym);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
